// File: rtl/display_pkg.sv
// Shared types and limits for the register display scheduler.
package display_pkg;

  localparam int unsigned MAX_SRC = 4;

  typedef logic [1:0] src_idx_t;
  typedef logic [7:0] disp_byte_t;

  typedef enum logic [0:0] {
    SHOW,
    BLANK
  } sched_state_e;

endpackage

// File: rtl/display_scheduler_if.sv
// Source taps in, display byte / indicator out, for display_scheduler.
interface display_scheduler_if
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC = MAX_SRC
);

  logic [NUM_SRC-1:0][7:0] src;
  logic                    auto_en;
  logic                    step;
  logic                    freeze;
  disp_byte_t              value;
  src_idx_t                sel;
  logic                    blank;
  logic                    update;

  // Register-file / button side.
  modport master (
    output src, auto_en, step, freeze,
    input  value, sel, blank, update
  );

  // Scheduler side.
  modport slave (
    input  src, auto_en, step, freeze,
    output value, sel, blank, update
  );

endinterface

// File: rtl/dwell_timer.sv
// Free-running terminal-count timer with clear and hold; tc pulses on the wrap cycle.
module dwell_timer
  import display_pkg::*;
#(
  parameter int unsigned COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tc
);

  localparam int unsigned CntW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(COUNT - 1);

  logic [CntW-1:0] cnt_q;

  // hold beats clear so a frozen count survives anything but reset
  assign tc = ~hold & ~clear & (cnt_q == Last);

  // Count state: hold, clear, wrap at terminal count, else increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hold) begin
      cnt_q <= cnt_q;
    end else if (clear || tc) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares one decimal display among NUM_SRC register taps, rotating on a
// dwell timer (auto) or on step edges (manual); freeze holds the shown value.
// Optional feature: define DISPLAY_SCHED_BLANK_EN to blank the digits for
// BLANK_CYCLES after each advance.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned BLANK_CYCLES = 5_000_000
) (
  input logic                clk,
  input logic                rst,
  display_scheduler_if.slave bus
);

  if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
    $error("display_scheduler: NUM_SRC must be 2..4");
  end
  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("display_scheduler: DWELL_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("display_scheduler: BLANK_CYCLES must be >= 1");
  end

  src_idx_t   sel_q;
  src_idx_t   next_sel;
  disp_byte_t value_q;
  logic       update_q;
  logic       step_q;
  logic       auto_q;
  logic       step_rise;
  logic       mode_change;
  logic       dwell_clear;
  logic       dwell_tc;
  logic       advance;

  assign step_rise   = bus.step & ~step_q;
  assign mode_change = bus.auto_en ^ auto_q;
  assign next_sel    = (sel_q == src_idx_t'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  // Edge/mode history always tracks its input, so edges during freeze or blank are lost.
  // auto_q resets to 1 so auto mode out of reset counts from the first edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
      auto_q <= 1'b1;
    end else begin
      step_q <= bus.step;
      auto_q <= bus.auto_en;
    end
  end

  dwell_timer #(
    .COUNT(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(dwell_clear),
    .hold (bus.freeze),
    .tc   (dwell_tc)
  );

`ifdef DISPLAY_SCHED_BLANK_EN

  sched_state_e state_q;
  logic         blank_q;
  logic         blank_tc;

  assign dwell_clear = mode_change | ~bus.auto_en | (state_q == BLANK);
  assign advance     = ~bus.freeze & (state_q == SHOW) &
                       (bus.auto_en ? dwell_tc : step_rise);

  dwell_timer #(
    .COUNT(BLANK_CYCLES)
  ) u_blank_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q != BLANK),
    .hold (bus.freeze),
    .tc   (blank_tc)
  );

  // SHOW/BLANK sequencing with registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SHOW;
      sel_q    <= '0;
      value_q  <= '0;
      blank_q  <= 1'b0;
      update_q <= 1'b0;
    end else if (bus.freeze) begin
      update_q <= 1'b0;
    end else if (advance) begin
      state_q  <= BLANK;
      sel_q    <= next_sel;
      value_q  <= '0;
      blank_q  <= 1'b1;
      update_q <= 1'b1;
    end else begin
      update_q <= 1'b0;
      unique case (state_q)
        SHOW: begin
          value_q <= bus.src[sel_q];
        end
        BLANK: begin
          if (blank_tc) begin
            state_q <= SHOW;
            blank_q <= 1'b0;
            value_q <= bus.src[sel_q];
          end else begin
            value_q <= '0;
          end
        end
        default: begin
          state_q <= SHOW;
        end
      endcase
    end
  end

  assign bus.blank = blank_q;

`else

  assign dwell_clear = mode_change | ~bus.auto_en;
  assign advance     = ~bus.freeze & (bus.auto_en ? dwell_tc : step_rise);

  // Source selection and live tracking of the selected tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      value_q  <= '0;
      update_q <= 1'b0;
    end else if (bus.freeze) begin
      update_q <= 1'b0;
    end else if (advance) begin
      sel_q    <= next_sel;
      value_q  <= bus.src[next_sel];
      update_q <= 1'b1;
    end else begin
      value_q  <= bus.src[sel_q];
      update_q <= 1'b0;
    end
  end

  assign bus.blank = 1'b0;

`endif

  assign bus.value  = value_q;
  assign bus.sel    = sel_q;
  assign bus.update = update_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the rotation rules.
module tb_display_scheduler;
  import display_pkg::*;

  localparam int unsigned NSRC   = 4;
  localparam int unsigned DWELL  = 4;
  localparam int unsigned BLANKC = 2;

  logic clk = 1'b0;
  logic rst;

  display_scheduler_if #(.NUM_SRC(NSRC)) bus ();

  display_scheduler #(
    .NUM_SRC     (NSRC),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANKC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: which source is shown, how long it has been shown, last step/mode.
  int m_sel;
  int m_age;
  int m_value;
  int m_update;
  bit m_prev_step;
  bit m_prev_auto;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_default_src();
    bus.src[0] = 8'd1;
    bus.src[1] = 8'd4;
    bus.src[2] = 8'd17;
    bus.src[3] = 8'd239;
  endtask

  task automatic model_reset();
    m_sel       = 0;
    m_age       = 0;
    m_value     = 0;
    m_update    = 0;
    m_prev_step = 1'b0;
    m_prev_auto = 1'b1;
  endtask

  // Assert reset between edges, check outputs at once, release on the next negedge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_sel", int'(bus.sel), 0);
    check("rst_value", int'(bus.value), 0);
    check("rst_update", int'(bus.update), 0);
    check("rst_blank", int'(bus.blank), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance the model by one clock using the inputs about to be sampled, then clock the DUT.
  task automatic cycle();
    bit adv;
    if (bus.freeze) begin
      m_update = 0;
    end else begin
      if (bus.auto_en) adv = (m_prev_auto == 1'b1) && (m_age == DWELL - 1);
      else             adv = bus.step && !m_prev_step;
      if (adv) begin
        m_sel    = (m_sel + 1) % NSRC;
        m_age    = 0;
        m_update = 1;
      end else begin
        m_update = 0;
        m_age    = (bus.auto_en && m_prev_auto) ? m_age + 1 : 0;
      end
      m_value = int'(bus.src[m_sel]);
    end
    m_prev_step = bus.step;
    m_prev_auto = bus.auto_en;
    tick();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_sel"}, int'(bus.sel), m_sel);
    check({tag, "_value"}, int'(bus.value), m_value);
    check({tag, "_update"}, int'(bus.update), m_update);
    check({tag, "_blank"}, int'(bus.blank), 0);
  endtask

  initial begin
    int idx;
    int r;
    rst         = 1'b0;
    bus.auto_en = 1'b1;
    bus.step    = 1'b0;
    bus.freeze  = 1'b0;
    set_default_src();
    model_reset();

`ifdef DISPLAY_SCHED_BLANK_EN
    // Manual step into blank; a step edge at the end of blank is dropped.
    bus.auto_en = 1'b0;
    apply_reset();
    tick();
    check("bl_idle_value", int'(bus.value), 1);
    bus.step = 1'b1;
    tick();
    check("bl_adv_sel", int'(bus.sel), 1);
    check("bl_adv_blank", int'(bus.blank), 1);
    check("bl_adv_value", int'(bus.value), 0);
    check("bl_adv_update", int'(bus.update), 1);
    bus.step = 1'b0;
    tick();
    check("bl_hold_blank", int'(bus.blank), 1);
    check("bl_hold_value", int'(bus.value), 0);
    bus.step = 1'b1;
    tick();
    check("bl_end_blank", int'(bus.blank), 0);
    check("bl_end_value", int'(bus.value), 4);
    check("bl_end_sel", int'(bus.sel), 1);
    tick();
    check("bl_drop_sel", int'(bus.sel), 1);
    check("bl_drop_update", int'(bus.update), 0);
`else
    // Auto rotation through all sources and wrap.
    apply_reset();
    for (int e = 1; e <= 16; e++) begin
      cycle();
      check_model("auto");
      if (e == 1) check("auto_e1_value", int'(bus.value), 1);
      if (e == 4) begin
        check("auto_e4_sel", int'(bus.sel), 1);
        check("auto_e4_value", int'(bus.value), 4);
        check("auto_e4_update", int'(bus.update), 1);
      end
      if (e == 12) check("auto_e12_value", int'(bus.value), 239);
      if (e == 16) begin
        check("auto_wrap_sel", int'(bus.sel), 0);
        check("auto_wrap_value", int'(bus.value), 1);
      end
    end

    // Manual: held step advances once, re-press advances again.
    bus.auto_en = 1'b0;
    apply_reset();
    bus.step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_model("held");
    end
    check("held_sel", int'(bus.sel), 1);
    bus.step = 1'b0;
    cycle();
    cycle();
    bus.step = 1'b1;
    cycle();
    check_model("repress");
    check("repress_sel", int'(bus.sel), 2);
    bus.step = 1'b0;

    // Freeze at count 2, then advance two cycles after release.
    bus.auto_en = 1'b1;
    apply_reset();
    cycle();
    cycle();
    bus.freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_model("frz");
      check("frz_sel", int'(bus.sel), 0);
      check("frz_value", int'(bus.value), 1);
    end
    bus.freeze = 1'b0;
    cycle();
    check("frz_rel1_sel", int'(bus.sel), 0);
    cycle();
    check("frz_rel2_sel", int'(bus.sel), 1);
    check("frz_rel2_update", int'(bus.update), 1);

    // Live tracking of the selected source.
    apply_reset();
    for (int i = 0; i < 5; i++) cycle();
    bus.src[1] = 8'd99;
    cycle();
    check_model("track");
    check("track_value", int'(bus.value), 99);
    check("track_update", int'(bus.update), 0);
    set_default_src();

    // Reset mid-dwell with sel=2, count=3.
    apply_reset();
    for (int i = 0; i < 11; i++) cycle();
    check("pre_rst_sel", int'(bus.sel), 2);
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check_model("post_rst");
      if (i < 4) check("post_rst_hold_sel", int'(bus.sel), 0);
    end
    check("post_rst_adv_sel", int'(bus.sel), 1);

    // Randomized traffic against the model.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 3) == 0) bus.step = ~bus.step;
      bus.freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, NSRC - 1));
        bus.src[idx] = 8'($urandom);
      end
      if (r == 99) apply_reset();
      cycle();
      check_model("rnd");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

- Time-shares the single 8-bit decimal display path (binary-to-BCD conversion plus three seven-segment digits) among up to four 8-bit register sources, e.g. A, X, Y and SP.
- Sits between the CPU register file taps and the display decoder: its registered `value` output feeds the decoder input, and `sel` drives a source-indicator LED.
- Rotation is automatic on a dwell timer, or manual on a step button; a freeze input holds the shown value.

## Interface
- `NUM_SRC`, 4, number of sources (2..4).
- `DWELL_CYCLES`, 50_000_000, clock cycles each source is shown in auto mode (≥2).
- `BLANK_CYCLES`, 5_000_000, blank interval after each advance (only with `DISPLAY_SCHED_BLANK_EN`, ≥1).
- `clk  input  1  system clock; all state on rising edge`
- `rst  input  1  asynchronous, active-high reset`
- `src  input  NUM_SRC×8  packed source array; src[i] is source i`
- `auto_en  input  1  1 = timed rotation, 0 = manual stepping`
- `step  input  1  manual advance, level (already debounced, synchronous to clk)`
- `freeze  input  1  hold value and sel`
- `value  output  8  registered byte to display decoder`
- `sel  output  2  index of source currently shown`
- `blank  output  1  1 = decoder must blank digits`
- `update  output  1  one-cycle pulse on each advance`

## Operation
- Reset, asynchronous: `value`=0, `sel`=0, `blank`=0, `update`=0; dwell counter=0; step edge register=0; state SHOW.
- Advance: `sel` ← (`sel`==`NUM_SRC`-1) ? 0 : `sel`+1; `value` ← `src[next sel]`; `update`=1 for that cycle; dwell counter ← 0.
- Auto mode (`auto_en`=1):
  - Counter increments 0..`DWELL_CYCLES`-1.
  - At terminal count the block advances.
  - `step` is ignored.
- Manual mode (`auto_en`=0):
  - Counter is held at 0.
  - A rising edge of `step` (`step` & ~`step_q`) advances exactly once.
  - A held level produces no repeats.
- Mode change: any change of `auto_en` clears the counter; after switching to auto, the first advance occurs `DWELL_CYCLES` cycles later.
- Non-advance cycles: `value` ← `src[sel]` (live tracking).
- Freeze (`freeze`=1) has top priority:
  - No advance and no resample; counter held.
  - Step edges seen during freeze are dropped.
  - On release, tracking resumes next cycle and the counter continues from its held value.
- Reset mid-dwell returns to source 0 immediately, regardless of other inputs.

## Timing
- `value` updates 1 cycle after a `src[sel]` change (one register stage).
- Advance, auto: `sel`, `value` and `update` change on the same edge, `DWELL_CYCLES` edges after the previous advance.
- Advance, manual: `sel` changes on the edge after `step` is first sampled high; 1 cycle of latency.
- Simultaneous terminal count and `step` edge in auto mode: timer advance only, a single step.

## Configuration
- Macro `DISPLAY_SCHED_BLANK_EN`.
- Defined:
  - FSM has SHOW and BLANK states.
  - Each advance enters BLANK for `BLANK_CYCLES` cycles: `blank`=1, `value`=0, `sel` already holds the new index.
  - Then SHOW, with `value` ← `src[sel]` on the first SHOW cycle.
  - Dwell counting restarts on entry to SHOW.
  - Step edges during BLANK are dropped.
  - `freeze` during BLANK extends BLANK.
- Undefined:
  - Single state; `blank` is tied 0.
  - `BLANK_CYCLES` is unused.

## Structure
- Shared package `display_pkg` holds:
  - `MAX_SRC`=4.
  - Typedef `src_idx_t` (logic [1:0]).
  - Typedef `disp_byte_t` (logic [7:0]).
  - State enum `sched_state_e` {SHOW, BLANK}.
- Sub-module `dwell_timer`:
  - Parameterised terminal count; width $clog2(count).
  - Inputs: `clear`, `hold`.
  - Outputs: `tc` pulse.
  - Instanced once for dwell and, under the macro, once for blank.

## Test plan
Common settings: `DWELL_CYCLES`=4, `BLANK_CYCLES`=2, src = {8'd239, 8'd17, 8'd4, 8'd1} (src[0]=1).
- Reset then auto_en=1 → value=1, sel=0; sel=1, value=4, update pulse at edge 4; sequence 4, 17, 239, then wraps to 1 at edge 16.
- auto_en=0, step held high 10 cycles → exactly one advance (sel 0→1); release and re-press → sel=2.
- auto_en=1, freeze=1 for 6 cycles at counter=2 → sel and value constant; after release, advance 2 cycles later.
- Change src[sel] from 4 to 99 mid-dwell → value=99 one cycle later, no update pulse.
- Assert rst at counter=3 with sel=2 → value=0 and sel=0 immediately; next advance 4 cycles after rst deasserts.
- With `DISPLAY_SCHED_BLANK_EN`: advance → blank=1, value=0 for 2 cycles; step during blank ignored; then value=src[new sel].
